// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multicycle MIPS datapath. Holds a word-addressed
//   RAM, completes writes in a single cycle and returns read data a fixed LATENCY
//   cycles after the read is accepted. Ready/RdValid let the controller handshake
//   instead of counting hard-coded wait states.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 4)
//   LATENCY  cycles from the read-accept edge to RdValid (>= 1)
//
// Ports
//   Clock    in   clock, all state updates on posedge
//   Reset    in   synchronous, active-low reset
//   Req      in   request strobe, accepted only while Ready=1
//   Wr       in   1 = write, 0 = read; sampled with Req
//   Addr     in   byte address; word index = Addr[$clog2(DEPTH)+1:2]
//   WrData   in   write data; sampled with Req & Wr
//   Ready    out  responder can accept a request this cycle
//   RdData   out  read data, valid with RdValid and held until the next response
//   RdValid  out  one-cycle read-response pulse
//   AddrErr  out  one-cycle pulse: accepted request had Addr[1:0] != 0
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic        Ready,
  output logic [31:0] RdData,
  output logic        RdValid,
  output logic        AddrErr
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RWAIT = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_q;
  logic          err_q;
  logic          aligned;
  logic          accept;
  logic          accept_rd;
  logic          resp_go;
  logic [IW-1:0] rd_idx;
  logic          rd_bad;
  logic [31:0]   mem [DEPTH];

  // Upper address bits alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:IW+2];

  assign Ready     = (state == S_IDLE);
  assign accept    = Req && Ready;
  assign accept_rd = accept && !Wr;
  assign aligned   = (Addr[1:0] == 2'b00);
  assign idx       = Addr[IW+1:2];

  // With LATENCY==1 the response is produced on the accept edge itself, so the
  // live address is used instead of the latched one.
  assign rd_idx = (LATENCY == 1) ? idx : idx_q;
  assign rd_bad = (LATENCY == 1) ? !aligned : err_q;

  always_comb begin
    state_nxt = state;
    resp_go   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept_rd) begin
          if (LATENCY == 1) begin
            state_nxt = S_RESP;
            resp_go   = 1'b1;
          end else begin
            state_nxt = S_RWAIT;
          end
        end
      end
      S_RWAIT: begin
        if (cnt == '0) begin
          state_nxt = S_RESP;
          resp_go   = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // RdValid/RdData are loaded on the edge that enters RESP, so the registered
  // pulse coincides exactly with the RESP cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      RdData  <= '0;
      RdValid <= 1'b0;
      AddrErr <= 1'b0;
    end else begin
      state   <= state_nxt;
      RdValid <= resp_go;
      AddrErr <= accept && !aligned;
      if (resp_go) begin
        RdData <= rd_bad ? '0 : mem[rd_idx];
      end
      if (accept_rd) begin
        idx_q <= idx;
        err_q <= !aligned;
        cnt   <= CW'(LATENCY - 2);
      end else if (state == S_RWAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset && accept && Wr && aligned) begin
      mem[idx] <= WrData;
    end
  end

  a_wr_known: assert property (@(posedge Clock) disable iff (!Reset) Req |-> !$isunknown(Wr));

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed scenarios with literal expectations followed by randomized traffic.
//   A transaction-level model (array memory plus a busy countdown) predicts
//   Ready/RdValid/RdData/AddrErr; a compare process checks them every cycle.
module tb_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        Clock;
  logic        Reset;
  logic        Req;
  logic        Wr;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic        Ready;
  logic [31:0] RdData;
  logic        RdValid;
  logic        AddrErr;

  int checks = 0;
  int errors = 0;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Req    (Req),
    .Wr     (Wr),
    .Addr   (Addr),
    .WrData (WrData),
    .Ready  (Ready),
    .RdData (RdData),
    .RdValid(RdValid),
    .AddrErr(AddrErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory array, written flags, and the number of edges
  // still to go before a pending read responds.
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  bit          started = 0;
  int          busy = 0;
  bit          e_ready = 1;
  bit          e_valid = 0;
  bit          e_err = 0;
  logic [31:0] e_data = '0;
  bit          e_known = 1;
  logic [31:0] pend_data = '0;
  bit          pend_known = 1;

  initial begin
    forever begin
      @(posedge Clock);
      if (!Reset) begin
        started = 1;
        busy    = 0;
        e_ready = 1;
        e_valid = 0;
        e_err   = 0;
        e_data  = '0;
        e_known = 1;
      end else if (started) begin
        e_valid = 0;
        e_err   = 0;
        if (busy > 0) begin
          busy--;
          if (busy == 0) begin
            e_valid = 1;
            e_data  = pend_data;
            e_known = pend_known;
          end
        end else if (e_ready && Req) begin
          int unsigned ix;
          bit          al;
          ix    = (Addr >> 2) % DEPTH;
          al    = (Addr % 4 == 0);
          e_err = !al;
          if (Wr) begin
            if (al) begin
              m_mem[ix] = WrData;
              m_wr[ix]  = 1;
            end
          end else begin
            pend_data  = al ? m_mem[ix] : 32'h0;
            pend_known = al ? m_wr[ix] : 1'b1;
            if (LATENCY == 1) begin
              e_valid = 1;
              e_data  = pend_data;
              e_known = pend_known;
            end else begin
              busy = LATENCY - 1;
            end
          end
        end
        e_ready = (busy == 0) && !e_valid;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clock);
      if (started) begin
        chk("m_ready", Ready, e_ready);
        chk("m_rdvalid", RdValid, e_valid);
        chk("m_addrerr", AddrErr, e_err);
        if (e_known) chk("m_rddata", RdData, e_data);
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    chk("wr_ready", Ready, 1);
    Req = 1; Wr = 1; Addr = a; WrData = d;
    @(negedge Clock);
    Req = 0;
    chk("wr_addrerr", AddrErr, (a[1:0] != 2'b00));
    chk("wr_ready_after", Ready, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d);
    int n;
    chk("rd_ready", Ready, 1);
    Req = 1; Wr = 0; Addr = a;
    @(negedge Clock);
    Req = 0;
    n = 1;
    chk("rd_addrerr", AddrErr, (a[1:0] != 2'b00));
    while (!RdValid && n < 10) begin
      chk("rd_busy", Ready, 0);
      @(negedge Clock);
      n++;
    end
    chk("rd_latency", n, LATENCY);
    chk("rd_valid", RdValid, 1);
    chk("rd_resp_busy", Ready, 0);
    chk("rd_data", RdData, exp_d);
    @(negedge Clock);
    chk("rd_pulse_end", RdValid, 0);
    chk("rd_ready_back", Ready, 1);
    chk("rd_data_held", RdData, exp_d);
  endtask

  initial begin
    int pulses;
    Reset = 0; Req = 0; Wr = 0; Addr = '0; WrData = '0;

    // 1. reset
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_ready", Ready, 1);
    chk("rst_rdvalid", RdValid, 0);
    chk("rst_rddata", RdData, 32'h0);
    chk("rst_addrerr", AddrErr, 0);
    Reset = 1;
    @(negedge Clock);
    chk("post_rst_ready", Ready, 1);

    // 2. write then read
    do_write(32'h10, 32'hDEADBEEF);
    do_read(32'h10, 32'hDEADBEEF);

    // 3. back-to-back writes, reads in order
    do_write(32'h0, 32'd1);
    do_write(32'h4, 32'd2);
    do_write(32'h8, 32'd3);
    do_read(32'h0, 32'd1);
    do_read(32'h4, 32'd2);
    do_read(32'h8, 32'd3);

    // 4. Req held high through the wait: one response, then a new read
    do_write(32'h20, 32'hA5A5A5A5);
    Req = 1; Wr = 0; Addr = 32'h20;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (i == 3) Req = 0;
      if (RdValid) begin
        pulses++;
        chk("hold_data", RdData, 32'hA5A5A5A5);
      end
    end
    chk("hold_pulses", pulses, 2);

    // 5. misaligned accesses
    do_write(32'h13, 32'h55);
    do_read(32'h10, 32'hDEADBEEF);
    do_read(32'h12, 32'h0);

    // 6. reset during the wait, then aliasing
    Req = 1; Wr = 0; Addr = 32'h10;
    @(negedge Clock);
    Req = 0; Reset = 0;
    @(negedge Clock);
    Reset = 1;
    chk("abort_rdvalid", RdValid, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      if (RdValid) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_ready", Ready, 1);
    do_write(32'h400, 32'h12345678);
    do_read(32'h000, 32'h12345678);

    // Randomized traffic, checked by the model
    for (int i = 0; i < 3000; i++) begin
      Reset  = ($urandom_range(0, 199) != 0);
      Req    = ($urandom_range(0, 2) != 0);
      Wr     = 1'($urandom_range(0, 1));
      Addr   = ($urandom & 32'hFFFFFC00) | ($urandom_range(0, 15) << 2)
               | (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 32'h0);
      WrData = $urandom;
      @(negedge Clock);
    end

    Req = 0; Reset = 1;
    repeat (5) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
